// File: rtl/id_stage_pipe_if.sv
// ID stage bus: IF/WB/hazard inputs towards the decoder and the registered ID/EX outputs.
interface id_stage_pipe_if #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned IWIDTH = 32,
  parameter int unsigned AWIDTH = 5
);
  logic              ids_i_ce;
  logic [IWIDTH-1:0] ids_i_instr;
  logic              ids_i_flush;
  logic              ids_i_ex_memread;
  logic [AWIDTH-1:0] ids_i_ex_rt;
  logic              ids_i_wb_en;
  logic [AWIDTH-1:0] ids_i_wb_addr;
  logic [DWIDTH-1:0] ids_i_wb_data;

  logic              ids_o_stall;
  logic              ids_o_ce;
  logic [5:0]        ids_o_opcode;
  logic [5:0]        ids_o_funct;
  logic [AWIDTH-1:0] ids_o_addr_rs;
  logic [AWIDTH-1:0] ids_o_addr_rt;
  logic [AWIDTH-1:0] ids_o_addr_wr;
  logic [DWIDTH-1:0] ids_o_data_rs;
  logic [DWIDTH-1:0] ids_o_data_rt;
  logic [DWIDTH-1:0] ids_o_imm;
  logic              ids_o_branch;
  logic              ids_o_alu_src;
  logic              ids_o_memread;
  logic              ids_o_memwrite;
  logic              ids_o_memtoreg;
  logic              ids_o_reg_wr;

  // Upstream side (IF/WB/EX feedback driver).
  modport master (
    output ids_i_ce, ids_i_instr, ids_i_flush, ids_i_ex_memread, ids_i_ex_rt,
    output ids_i_wb_en, ids_i_wb_addr, ids_i_wb_data,
    input  ids_o_stall, ids_o_ce, ids_o_opcode, ids_o_funct, ids_o_addr_rs, ids_o_addr_rt,
    input  ids_o_addr_wr, ids_o_data_rs, ids_o_data_rt, ids_o_imm, ids_o_branch,
    input  ids_o_alu_src, ids_o_memread, ids_o_memwrite, ids_o_memtoreg, ids_o_reg_wr
  );

  // Decode stage side.
  modport slave (
    input  ids_i_ce, ids_i_instr, ids_i_flush, ids_i_ex_memread, ids_i_ex_rt,
    input  ids_i_wb_en, ids_i_wb_addr, ids_i_wb_data,
    output ids_o_stall, ids_o_ce, ids_o_opcode, ids_o_funct, ids_o_addr_rs, ids_o_addr_rt,
    output ids_o_addr_wr, ids_o_data_rs, ids_o_data_rt, ids_o_imm, ids_o_branch,
    output ids_o_alu_src, ids_o_memread, ids_o_memwrite, ids_o_memtoreg, ids_o_reg_wr
  );
endinterface

// File: rtl/id_stage_pipe.sv
// MIPS instruction-decode stage: main decoder, register file with write-through bypass,
// load-use hazard detection and a registered ID/EX boundary with bubble insertion.
module id_stage_pipe #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned IWIDTH = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned AWIDTH = 5
) (
  input logic            ids_clk,
  input logic            ids_rst,
  id_stage_pipe_if.slave bus
);
  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;

  logic [5:0]        opcode, funct;
  logic [AWIDTH-1:0] rs, rt, rd, addr_wr;
  logic [DWIDTH-1:0] imm, data_rs, data_rt;
  logic              reg_dst, branch, alu_src, memread, memwrite, memtoreg, reg_wr;
  logic              uses_rt, stall;
  logic              rs_ok, rt_ok, wb_ok;
  logic              wb_hit;

  logic [DWIDTH-1:0] rf_q [NREGS];

  logic              ce_q, branch_q, alu_src_q, memread_q, memwrite_q, memtoreg_q, reg_wr_q;
  logic [5:0]        opcode_q, funct_q;
  logic [AWIDTH-1:0] addr_rs_q, addr_rt_q, addr_wr_q;
  logic [DWIDTH-1:0] data_rs_q, data_rt_q, imm_q;

  assign opcode = bus.ids_i_instr[31:26];
  assign funct  = bus.ids_i_instr[5:0];
  assign rs     = AWIDTH'(bus.ids_i_instr[25:21]);
  assign rt     = AWIDTH'(bus.ids_i_instr[20:16]);
  assign rd     = AWIDTH'(bus.ids_i_instr[15:11]);
  assign imm    = DWIDTH'(signed'(bus.ids_i_instr[15:0]));

  // Addresses beyond the implemented file only exist when the address space is larger.
  if (NREGS < (32'd1 << AWIDTH)) begin : g_range
    assign rs_ok = 32'(rs) < NREGS;
    assign rt_ok = 32'(rt) < NREGS;
    assign wb_ok = 32'(bus.ids_i_wb_addr) < NREGS;
  end else begin : g_full
    assign rs_ok = 1'b1;
    assign rt_ok = 1'b1;
    assign wb_ok = 1'b1;
  end

  assign wb_hit = bus.ids_i_wb_en && (bus.ids_i_wb_addr != '0) && wb_ok;

  // Main decoder: control lines per opcode, anything unknown decodes as a NOP.
  always_comb begin
    reg_dst  = 1'b0;
    branch   = 1'b0;
    alu_src  = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    memtoreg = 1'b0;
    reg_wr   = 1'b0;
    case (opcode)
      OpRtype: begin reg_dst = 1'b1; reg_wr = 1'b1; end
      OpLw:    begin alu_src = 1'b1; memread = 1'b1; memtoreg = 1'b1; reg_wr = 1'b1; end
      OpSw:    begin alu_src = 1'b1; memwrite = 1'b1; end
      OpBeq:   branch = 1'b1;
      OpAddi:  begin alu_src = 1'b1; reg_wr = 1'b1; end
      default: ;
    endcase
  end

  assign addr_wr = reg_dst ? rd : rt;

  // Register read with write-through bypass; r0 and unimplemented addresses read as zero.
  always_comb begin
    data_rs = '0;
    data_rt = '0;
    if (rs != '0 && rs_ok) begin
      data_rs = (wb_hit && bus.ids_i_wb_addr == rs) ? bus.ids_i_wb_data : rf_q[rs];
    end
    if (rt != '0 && rt_ok) begin
      data_rt = (wb_hit && bus.ids_i_wb_addr == rt) ? bus.ids_i_wb_data : rf_q[rt];
    end
  end

  // Load-use hazard: rt is only a source for R-type, sw and beq; a flush overrides it.
  always_comb begin
    uses_rt = (opcode == OpRtype) || (opcode == OpSw) || (opcode == OpBeq);
    stall   = bus.ids_i_ce && bus.ids_i_ex_memread && (bus.ids_i_ex_rt != '0) &&
              ((bus.ids_i_ex_rt == rs) || ((bus.ids_i_ex_rt == rt) && uses_rt)) &&
              !bus.ids_i_flush;
  end

  // Register file write port; reset wipes the file and blocks any same-cycle write-back.
  always_ff @(posedge ids_clk) begin
    if (ids_rst) begin
      for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (wb_hit) begin
      rf_q[bus.ids_i_wb_addr] <= bus.ids_i_wb_data;
    end
  end

  // ID/EX boundary: reset, flush, stall and invalid input all collapse to the all-zero bubble.
  always_ff @(posedge ids_clk) begin
    if (ids_rst || bus.ids_i_flush || stall || !bus.ids_i_ce) begin
      ce_q       <= 1'b0;
      opcode_q   <= '0;
      funct_q    <= '0;
      addr_rs_q  <= '0;
      addr_rt_q  <= '0;
      addr_wr_q  <= '0;
      data_rs_q  <= '0;
      data_rt_q  <= '0;
      imm_q      <= '0;
      branch_q   <= 1'b0;
      alu_src_q  <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      reg_wr_q   <= 1'b0;
    end else begin
      ce_q       <= 1'b1;
      opcode_q   <= opcode;
      funct_q    <= funct;
      addr_rs_q  <= rs;
      addr_rt_q  <= rt;
      addr_wr_q  <= addr_wr;
      data_rs_q  <= data_rs;
      data_rt_q  <= data_rt;
      imm_q      <= imm;
      branch_q   <= branch;
      alu_src_q  <= alu_src;
      memread_q  <= memread;
      memwrite_q <= memwrite;
      memtoreg_q <= memtoreg;
      reg_wr_q   <= reg_wr;
    end
  end

  assign bus.ids_o_stall    = stall;
  assign bus.ids_o_ce       = ce_q;
  assign bus.ids_o_opcode   = opcode_q;
  assign bus.ids_o_funct    = funct_q;
  assign bus.ids_o_addr_rs  = addr_rs_q;
  assign bus.ids_o_addr_rt  = addr_rt_q;
  assign bus.ids_o_addr_wr  = addr_wr_q;
  assign bus.ids_o_data_rs  = data_rs_q;
  assign bus.ids_o_data_rt  = data_rt_q;
  assign bus.ids_o_imm      = imm_q;
  assign bus.ids_o_branch   = branch_q;
  assign bus.ids_o_alu_src  = alu_src_q;
  assign bus.ids_o_memread  = memread_q;
  assign bus.ids_o_memwrite = memwrite_q;
  assign bus.ids_o_memtoreg = memtoreg_q;
  assign bus.ids_o_reg_wr   = reg_wr_q;
endmodule
